// File: rtl/multdiv_sequencer_pkg.sv
// Shared types and constants for the multi-cycle multiply/divide sequencer.
// Holds the FSM encoding, ALU opcodes and the sign/magnitude helpers.
package multdiv_sequencer_pkg;

    localparam int ITER_DEF = 32;

    localparam logic [4:0] ALU_MULT = 5'b00110;
    localparam logic [4:0] ALU_DIV  = 5'b00111;

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_MUL  = 2'd1,
        ST_DIV  = 2'd2,
        ST_DONE = 2'd3
    } state_e;

    function automatic logic [31:0] mag32(input logic [31:0] x);
        return x[31] ? (~x + 32'd1) : x;
    endfunction

    function automatic logic [63:0] neg_if64(input logic neg, input logic [63:0] x);
        return neg ? (~x + 64'd1) : x;
    endfunction

endpackage

// File: rtl/multdiv_sequencer_datapath.sv
// Iterative unsigned datapath: shift-add multiply and restoring divide on
// magnitudes, sharing one 33-bit adder/subtractor and a 64-bit accumulator.
module multdiv_datapath
    import multdiv_sequencer_pkg::*;
#(
    parameter int ITER = ITER_DEF
) (
    input  logic        clk_i,
    input  logic        rst_ni,
    input  logic        load_i,
    input  logic        step_i,
    input  logic        op_div_i,
    input  logic [31:0] a_mag_i,
    input  logic [31:0] b_mag_i,
    output logic [63:0] acc_nxt_o,
    output logic        last_o
);

    localparam int CW = (ITER > 1) ? $clog2(ITER) : 1;

    logic [63:0]   acc_q, acc_d;
    logic [31:0]   opb_q;
    logic [CW-1:0] cnt_q;

    logic [63:0] shl;
    logic [31:0] add_x;
    logic [32:0] add_y;
    logic [32:0] sum;

    // Multiply adds into the upper half before shifting right; divide shifts
    // left first and trial-subtracts the divisor (sum[32] set = borrow).
    assign shl   = {acc_q[62:0], 1'b0};
    assign add_x = op_div_i ? shl[63:32] : acc_q[63:32];
    assign add_y = op_div_i ? ~{1'b0, opb_q} : {1'b0, opb_q};
    assign sum   = {1'b0, add_x} + add_y + {32'd0, op_div_i};

    always_comb begin
        acc_d = acc_q;
        if (op_div_i) begin
            acc_d = sum[32] ? shl : {sum[31:0], shl[31:1], 1'b1};
        end else begin
            acc_d = acc_q[0] ? {sum, acc_q[31:1]} : {1'b0, acc_q[63:1]};
        end
    end

    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            acc_q <= '0;
            opb_q <= '0;
            cnt_q <= '0;
        end else if (load_i) begin
            acc_q <= {32'd0, a_mag_i};
            opb_q <= b_mag_i;
            cnt_q <= '0;
        end else if (step_i) begin
            acc_q <= acc_d;
            cnt_q <= cnt_q + CW'(1);
        end
    end

    assign acc_nxt_o = acc_d;
    assign last_o    = (cnt_q == CW'(ITER - 1));

endmodule

// File: rtl/multdiv_sequencer.sv
// Execute-stage multiply/divide controller: stalls the pipeline while the
// iterative datapath runs, then strobes a signed result for one cycle.
module multdiv_sequencer
    import multdiv_sequencer_pkg::*;
#(
    parameter int ITER = ITER_DEF
) (
    input  logic        clock,
    input  logic        reset,
    input  logic        ctrl_MULT,
    input  logic        ctrl_DIV,
    input  logic [31:0] data_operandA,
    input  logic [31:0] data_operandB,
    output logic [31:0] data_result,
    output logic        data_exception,
    output logic        data_resultRDY,
    output logic        stall
);

    state_e      state_q;
    logic        sign_q;
    logic        dzero_q;
    logic        rdy_q;
    logic        exc_q;
    logic [31:0] res_q;

    logic        idle, start_mul, start_div, start, busy, last;
    logic [63:0] acc_nxt;
    logic [63:0] prod_s;
    logic        mul_exc;
    logic [31:0] quot_mag, quot_s;
    logic        div_exc;

    // Reset gating keeps stall at 0 while reset is held, even with a pulse present.
    assign idle      = (state_q == ST_IDLE);
    assign start_mul = reset & idle & ctrl_MULT;
    assign start_div = reset & idle & ctrl_DIV & ~ctrl_MULT;
    assign start     = start_mul | start_div;
    assign busy      = (state_q == ST_MUL) | (state_q == ST_DIV);
    assign stall     = start | busy;

    multdiv_datapath #(.ITER(ITER)) u_dp (
        .clk_i    (clock),
        .rst_ni   (reset),
        .load_i   (start),
        .step_i   (busy),
        .op_div_i (state_q == ST_DIV),
        .a_mag_i  (mag32(data_operandA)),
        .b_mag_i  (mag32(data_operandB)),
        .acc_nxt_o(acc_nxt),
        .last_o   (last)
    );

    // Fix-up works on the final step's value so the result lands in DONE.
    assign prod_s   = neg_if64(sign_q, acc_nxt);
    assign mul_exc  = (prod_s[63:32] != {32{prod_s[31]}});
    assign quot_mag = acc_nxt[31:0];
    assign quot_s   = sign_q ? (~quot_mag + 32'd1) : quot_mag;
    // A positive quotient with bit 31 set only arises from MIN / -1.
    assign div_exc  = ~sign_q & quot_mag[31];

    always_ff @(posedge clock or negedge reset) begin
        if (!reset) begin
            state_q <= ST_IDLE;
            sign_q  <= 1'b0;
            dzero_q <= 1'b0;
            rdy_q   <= 1'b0;
            exc_q   <= 1'b0;
            res_q   <= '0;
        end else begin
            rdy_q <= 1'b0;
            case (state_q)
                ST_IDLE: begin
                    if (start) begin
                        state_q <= start_mul ? ST_MUL : ST_DIV;
                        sign_q  <= data_operandA[31] ^ data_operandB[31];
                        dzero_q <= start_div & (data_operandB == 32'd0);
                    end
                end
                ST_MUL: begin
                    if (last) begin
                        state_q <= ST_DONE;
                        rdy_q   <= 1'b1;
                        res_q   <= prod_s[31:0];
                        exc_q   <= mul_exc;
                    end
                end
                ST_DIV: begin
                    if (dzero_q) begin
                        state_q <= ST_DONE;
                        rdy_q   <= 1'b1;
                        res_q   <= '0;
                        exc_q   <= 1'b1;
                    end else if (last) begin
                        state_q <= ST_DONE;
                        rdy_q   <= 1'b1;
                        res_q   <= quot_s;
                        exc_q   <= div_exc;
                    end
                end
                ST_DONE: state_q <= ST_IDLE;
                default: state_q <= ST_IDLE;
            endcase
        end
    end

    assign data_result    = res_q;
    assign data_exception = exc_q;
    assign data_resultRDY = rdy_q;

endmodule

// File: tb/tb_multdiv_sequencer.sv
// Self-checking bench for multdiv_sequencer: directed cases plus random
// operands checked against a plain-arithmetic signed multiply/divide model.
module tb_multdiv_sequencer;

    logic        clock = 1'b0;
    logic        reset = 1'b0;
    logic        ctrl_MULT = 1'b0;
    logic        ctrl_DIV = 1'b0;
    logic [31:0] data_operandA = '0;
    logic [31:0] data_operandB = '0;
    logic [31:0] data_result;
    logic        data_exception;
    logic        data_resultRDY;
    logic        stall;

    int checks = 0;
    int passes = 0;
    int fails  = 0;

    multdiv_sequencer dut (
        .clock         (clock),
        .reset         (reset),
        .ctrl_MULT     (ctrl_MULT),
        .ctrl_DIV      (ctrl_DIV),
        .data_operandA (data_operandA),
        .data_operandB (data_operandB),
        .data_result   (data_result),
        .data_exception(data_exception),
        .data_resultRDY(data_resultRDY),
        .stall         (stall)
    );

    always #5 clock = ~clock;

    task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        checks++;
        assert (obs === exp) passes++;
        else begin
            fails++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    // Reference: signed 64-bit product / truncating signed quotient.
    function automatic void model(input bit dv, input logic [31:0] a, input logic [31:0] b,
                                  output logic [31:0] r, output logic e);
        int     sa, sb, lo, q;
        longint p;
        sa = a;
        sb = b;
        if (!dv) begin
            p  = longint'(sa) * longint'(sb);
            lo = p[31:0];
            r  = p[31:0];
            e  = (p != longint'(lo));
        end else if (sb == 0) begin
            r = 32'd0;
            e = 1'b1;
        end else if (a == 32'h8000_0000 && b == 32'hFFFF_FFFF) begin
            r = 32'h8000_0000;
            e = 1'b1;
        end else begin
            q = sa / sb;
            r = q;
            e = 1'b0;
        end
    endfunction

    // Called at the pulse cycle; returns at the negedge inside the RDY cycle.
    task automatic wait_rdy(input int poke_cyc, output int lat, output int stalls);
        stalls = 0;
        @(negedge clock);
        lat = 1;
        ctrl_MULT = 1'b0;
        ctrl_DIV  = 1'b0;
        while (data_resultRDY !== 1'b1 && lat < 80) begin
            if (stall === 1'b1) stalls++;
            ctrl_DIV = (lat == poke_cyc);
            @(negedge clock);
            lat++;
        end
        ctrl_DIV = 1'b0;
    endtask

    task automatic do_op(input bit dv, input bit both, input logic [31:0] a, input logic [31:0] b,
                         input int poke, input string tag);
        logic [31:0] er;
        logic        ee;
        int          lat, st, elat;
        model(dv, a, b, er, ee);
        elat = (dv && b == 32'd0) ? 2 : 33;
        @(negedge clock);
        data_operandA = a;
        data_operandB = b;
        ctrl_MULT = !dv;
        ctrl_DIV  = dv | both;
        #1;
        chk({tag, "_stall_pulse"}, stall, 1);
        wait_rdy(poke, lat, st);
        chk({tag, "_latency"}, lat, elat);
        chk({tag, "_stall_cycles"}, st, elat - 1);
        chk({tag, "_stall_done"}, stall, 0);
        chk({tag, "_result"}, data_result, er);
        chk({tag, "_exc"}, data_exception, ee);
        @(negedge clock);
        chk({tag, "_rdy_1cyc"}, data_resultRDY, 0);
    endtask

    initial begin
        int lat, st, rdy_seen;
        bit dv;
        int sel;
        logic [31:0] a, b;

        // Reset state, including stall suppressed while reset is held.
        #12;
        chk("rst_result", data_result, 0);
        chk("rst_exc", data_exception, 0);
        chk("rst_rdy", data_resultRDY, 0);
        chk("rst_stall", stall, 0);
        ctrl_MULT = 1'b1;
        #1;
        chk("rst_stall_pulse", stall, 0);
        ctrl_MULT = 1'b0;
        @(negedge clock);
        reset = 1'b1;

        do_op(0, 0, 32'd7, 32'hFFFF_FFFA, -1, "mul_7_m6");
        chk("mul_7_m6_hold", data_result, 32'hFFFF_FFD6);
        do_op(0, 0, 32'h0001_0000, 32'h0001_0000, -1, "mul_ovf");
        chk("mul_ovf_hold_exc", data_exception, 1);
        do_op(1, 0, 32'hFFFF_FFEF, 32'd5, -1, "div_m17_5");
        chk("div_m17_5_hold", data_result, 32'hFFFF_FFFD);
        do_op(1, 0, 32'd5, 32'd0, -1, "div_by0");
        do_op(1, 0, 32'h8000_0000, 32'hFFFF_FFFF, -1, "div_min_m1");
        chk("div_min_m1_hold", data_result, 32'h8000_0000);
        do_op(0, 1, 32'd9, 32'hFFFF_FFFD, -1, "both_is_mul");
        chk("both_is_mul_hold", data_result, 32'hFFFF_FFE5);
        do_op(0, 0, 32'd1234, 32'hFFFF_E9D2, 10, "mul_div_poke");

        // Back-to-back: pulse in DONE is dropped, pulse in following IDLE accepted.
        @(negedge clock);
        data_operandA = 32'd4;
        data_operandB = 32'd5;
        ctrl_MULT = 1'b1;
        #1;
        wait_rdy(-1, lat, st);
        chk("b2b_first_lat", lat, 33);
        chk("b2b_first_res", data_result, 32'd20);
        data_operandA = 32'd6;
        data_operandB = 32'd7;
        ctrl_MULT = 1'b1;
        #1;
        chk("b2b_done_stall", stall, 0);
        @(negedge clock);
        chk("b2b_done_rdy_clear", data_resultRDY, 0);
        wait_rdy(-1, lat, st);
        chk("b2b_second_lat", lat, 33);
        chk("b2b_second_res", data_result, 32'd42);
        @(negedge clock);

        // Reset mid-divide discards the operation.
        @(negedge clock);
        data_operandA = 32'hFFFF_FF9C;
        data_operandB = 32'd7;
        ctrl_DIV = 1'b1;
        #1;
        for (int i = 1; i <= 15; i++) begin
            @(negedge clock);
            ctrl_DIV = 1'b0;
        end
        chk("rst_mid_busy", stall, 1);
        #2;
        reset = 1'b0;
        #1;
        chk("rst_mid_result", data_result, 0);
        chk("rst_mid_exc", data_exception, 0);
        chk("rst_mid_rdy", data_resultRDY, 0);
        chk("rst_mid_stall", stall, 0);
        repeat (2) @(negedge clock);
        reset = 1'b1;
        rdy_seen = 0;
        for (int i = 0; i < 40; i++) begin
            @(negedge clock);
            if (data_resultRDY === 1'b1) rdy_seen++;
        end
        chk("rst_mid_no_rdy", rdy_seen, 0);
        do_op(0, 0, 32'd3, 32'd3, -1, "mul_3x3_post_rst");
        chk("mul_3x3_hold", data_result, 32'd9);

        // Random operands.
        for (int n = 0; n < 24; n++) begin
            dv  = 1'($urandom_range(0, 1));
            sel = $urandom_range(0, 5);
            a   = $urandom;
            b   = $urandom;
            case (sel)
                0: b = 32'd0;
                1: begin
                    a = 32'($urandom_range(0, 400)) - 32'd200;
                    b = 32'($urandom_range(0, 40)) - 32'd20;
                end
                2: b = 32'($urandom_range(1, 1000));
                3: a = 32'h8000_0000;
                default: ;
            endcase
            do_op(dv, 0, a, b, -1, $sformatf("rnd%0d", n));
        end

        $display("%0d/%0d checks passed", passes, checks);
        $finish;
    end

endmodule

// File: doc/multdiv_sequencer.md
# multdiv_sequencer

Multi-cycle multiply/divide controller for the processor's execute stage. Accepts a one-cycle MULT or DIV start pulse, holds the pipeline with `stall` while a 32-iteration shift-add multiply or restoring divide runs, then presents a 32-bit result and exception flag for exactly one cycle so the XM latch can capture it. Sits beside the ALU; the processor's next-PC, FD and DX latches gate their enables on `stall`.

## Interface
Parameters
- `ITER`, 32: number of iteration cycles per operation; equals operand width.

Ports
- `clock` in 1: master clock; all state updates on the rising edge.
- `reset` in 1: asynchronous, active-low; low forces IDLE immediately.
- `ctrl_MULT` in 1: start multiply; one-cycle pulse, valid only in IDLE.
- `ctrl_DIV` in 1: start divide; one-cycle pulse, valid only in IDLE.
- `data_operandA` in 32: multiplicand or dividend, two's complement; sampled on the start edge only.
- `data_operandB` in 32: multiplier or divisor, two's complement; sampled on the start edge only.
- `data_result` out 32: product low word or quotient; valid when `data_resultRDY`=1.
- `data_exception` out 1: overflow or divide-by-zero; valid when `data_resultRDY`=1.
- `data_resultRDY` out 1: one-cycle result-valid strobe.
- `stall` out 1: hold PC/FD/DX and insert a bubble into XM.

## Operation
- States: IDLE, MUL, DIV, DONE.
- Start signal sampling:
  - IDLE with `ctrl_MULT`=1 goes to MUL.
  - IDLE with `ctrl_DIV`=1 goes to DIV.
  - If both are 1, MULT wins.
  - Operand magnitudes, result sign (A[31]^B[31]) and counter=0 are loaded on the start edge.
  - Start pulses outside IDLE are ignored.
- MUL: one shift-add step per cycle on the 32-bit magnitudes into a 64-bit accumulator. When counter reaches `ITER`-1, go to DONE.
  - Result: the signed 64-bit product, low 32 bits.
  - Exception: set when the signed product's upper 32 bits are not the sign-extension of bit 31.
- DIV: one restoring step per cycle (shift, trial subtract, restore on negative). When counter reaches `ITER`-1, go to DONE.
  - Quotient is truncated toward zero; the remainder is discarded.
  - Divisor = 0, detected on the start edge: go straight to DONE on the next edge with result 0 and exception 1.
  - 0x80000000 / -1: result 0x80000000, exception 1.
- DONE: `data_resultRDY`=1 and `stall`=0 for one cycle, then unconditionally return to IDLE. A start pulse seen in DONE is ignored.
- `stall` = (IDLE & (`ctrl_MULT` | `ctrl_DIV`)) | MUL | DIV. It is combinational on the start pulse so the issuing instruction is held in the same cycle.
- `data_result` and `data_exception` are registered; they hold their last value outside DONE, and 0 after reset.
- Reset (`reset`=0) at any time: state=IDLE, counter=0, all outputs 0. An in-flight operation is discarded and no RDY pulse is produced.

## Timing
- The start edge is t0.
- MUL/DIV iteration edges are t1..t32; DONE is entered at t32, so `data_resultRDY`=1 during the cycle after t32 (latency 33 cycles from the pulse).
- Divide-by-zero: DONE is entered at t1, so RDY is high in the cycle after t1.
- `stall` is high from the pulse cycle through the last MUL/DIV cycle, and low in DONE.
- The next start is accepted on the edge that leaves DONE at the earliest (back-to-back ops are separated by the DONE cycle).

## Structure
- Shared package:
  - ALU opcodes `ALU_MULT`=5'b00110 and `ALU_DIV`=5'b00111.
  - State encoding: IDLE=2'd0, MUL=2'd1, DIV=2'd2, DONE=2'd3.
  - `ITER` default.
- One sub-module, `multdiv_datapath`:
  - Contains the 64-bit accumulator/remainder, 32-bit operand regs, 5-bit counter and a single 33-bit adder/subtractor shared by MUL and DIV.
  - Controlled by load/step/op-select from the FSM.
- The FSM, stall logic and sign/exception fix-up stay in the top module.

## Test plan
- MULT A=7, B=-6: `stall` high for 33 cycles, then RDY for 1 cycle with result 0xFFFFFFD6 (-42) and exception 0.
- MULT A=0x00010000, B=0x00010000: result 0x00000000, exception 1 (overflow).
- DIV A=-17, B=5: result 0xFFFFFFFD (-3), exception 0, RDY in cycle 33. DIV A=5, B=0: RDY in cycle 2, result 0, exception 1.
- DIV A=0x80000000, B=-1: result 0x80000000, exception 1. Also: MULT and DIV pulsed together behaves as MULT.
- Pulse `ctrl_DIV` at iteration 10 of a MULT: it is ignored, and the MULT result and timing are unchanged. Back-to-back MULT pulsed in the DONE cycle is ignored; a pulse in the following IDLE cycle is accepted.
- Assert `reset` low at iteration 15 of a DIV: all outputs go to 0 asynchronously and no RDY pulse follows. After release, a new MULT 3×3 returns 9 with the full 33-cycle latency.
